// File: rtl/seq_tail_light_controller.sv
// seq_tail_light_controller
// Sequential (Mustang-style) turn pattern over LAMPS lamps per side, paced by a
// STEP_DIV-clock prescaler, with brake blended onto the non-sequencing side.
// Optional feature macro: HAZARD_EN (hazard input sequences both sides in lockstep).
module seq_tail_light_controller #(
    parameter int unsigned LAMPS    = 3,
    parameter int unsigned STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             brake,
    input  logic             turn_right,
    input  logic             turn_left,
    input  logic             hazard,
    output logic [LAMPS-1:0] right_tail_light_control,
    output logic [LAMPS-1:0] left_tail_light_control,
    output logic             seq_active
);

    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned SW = $clog2(LAMPS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(LAMPS);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [1:0]        r_set;     // {SEQ_L, SEQ_R} seen at the previous edge
    logic [1:0]        w_set;
    logic [SW-1:0]     r_step;
    logic [SW-1:0]     w_step_d;
    logic [PW-1:0]     r_presc;
    logic [PW-1:0]     w_presc_d;
    logic [LAMPS-1:0]  w_pat;
    logic [LAMPS-1:0]  w_right_d;
    logic [LAMPS-1:0]  w_left_d;
    logic              w_active_d;
    logic              w_one_turn;

    assign w_one_turn = turn_right ^ turn_left;

`ifdef HAZARD_EN
    assign w_set = hazard ? 2'b11 : {turn_left & w_one_turn, turn_right & w_one_turn};
`else
    logic w_unused_hazard;
    assign w_unused_hazard = hazard;
    assign w_set = {turn_left & w_one_turn, turn_right & w_one_turn};
`endif

    // State, shared step/prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state                  <= StIdle;
            r_set                    <= 2'b00;
            r_step                   <= '0;
            r_presc                  <= '0;
            right_tail_light_control <= '0;
            left_tail_light_control  <= '0;
            seq_active               <= 1'b0;
        end else begin
            r_state                  <= w_state_d;
            r_set                    <= w_set;
            r_step                   <= w_step_d;
            r_presc                  <= w_presc_d;
            right_tail_light_control <= w_right_d;
            left_tail_light_control  <= w_left_d;
            seq_active               <= w_active_d;
        end
    end

    // Next state: restart on entry or on a change of the sequencing set.
    always_comb begin
        w_state_d = r_state;
        w_step_d  = r_step;
        w_presc_d = r_presc;
        if (w_set == 2'b00) begin
            w_state_d = StIdle;
            w_step_d  = '0;
            w_presc_d = '0;
        end else if (r_state == StIdle || w_set != r_set) begin
            w_state_d = StRun;
            w_step_d  = SW'(1);
            w_presc_d = '0;
        end else if (r_presc == PRESC_LAST) begin
            w_presc_d = '0;
            w_step_d  = (r_step == STEP_LAST) ? '0 : r_step + SW'(1);
        end else begin
            w_presc_d = r_presc + PW'(1);
        end
    end

    // Outputs: thermometer pattern on sequencing sides, brake value elsewhere.
    always_comb begin
        w_pat = '0;
        for (int i = 0; i < int'(LAMPS); i++) begin
            w_pat[i] = (i < int'(w_step_d));
        end
        w_right_d  = w_set[0] ? w_pat : {LAMPS{brake}};
        w_left_d   = w_set[1] ? w_pat : {LAMPS{brake}};
        w_active_d = (w_state_d == StRun);
    end

endmodule

// File: tb/tb_seq_tail_light_controller.sv
// Table-driven bench for seq_tail_light_controller (LAMPS=3, STEP_DIV=4).
// Honours HAZARD_EN in the same way as the design.
module tb_seq_tail_light_controller;

    logic       clk;
    logic       rst_n;
    logic       brake;
    logic       turn_right;
    logic       turn_left;
    logic       hazard;
    logic [2:0] right_o;
    logic [2:0] left_o;
    logic       act_o;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       b;
        logic       tr;
        logic       tl;
        logic       hz;
        logic [2:0] er;
        logic [2:0] el;
        logic       ea;
    } vec_t;

    vec_t vq[$];

    seq_tail_light_controller #(
        .LAMPS    (3),
        .STEP_DIV (4)
    ) u_dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .brake                    (brake),
        .turn_right               (turn_right),
        .turn_left                (turn_left),
        .hazard                   (hazard),
        .right_tail_light_control (right_o),
        .left_tail_light_control  (left_o),
        .seq_active               (act_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] pat(input int step);
        case (step)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    task automatic add(input logic b, input logic tr, input logic tl, input logic hz,
                       input logic [2:0] er, input logic [2:0] el, input logic ea);
        vec_t v;
        v.b = b; v.tr = tr; v.tl = tl; v.hz = hz;
        v.er = er; v.el = el; v.ea = ea;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] er, input logic [2:0] el,
                         input logic ea);
        n_vec++;
        if (right_o !== er || left_o !== el || act_o !== ea) begin
            n_bad++;
            $display("FAIL %s: got R=%b L=%b act=%b, want R=%b L=%b act=%b",
                     name, right_o, left_o, act_o, er, el, ea);
        end
    endtask

    task automatic drive(input logic b, input logic tr, input logic tl, input logic hz);
        @(negedge clk);
        brake = b; turn_right = tr; turn_left = tl; hazard = hz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        brake = 0; turn_right = 0; turn_left = 0; hazard = 0;

        // Basic combinations from idle.
        add(0, 0, 0, 0, 3'b000, 3'b000, 0);
        add(1, 0, 0, 0, 3'b111, 3'b111, 0);
        add(0, 0, 0, 0, 3'b000, 3'b000, 0);
        add(0, 1, 1, 0, 3'b000, 3'b000, 0);
        add(1, 1, 1, 0, 3'b111, 3'b111, 0);
        add(0, 0, 0, 0, 3'b000, 3'b000, 0);
        // Held right turn: full period plus wrap back to one lamp.
        for (int k = 0; k < 17; k++) add(0, 1, 0, 0, pat((k / 4 + 1) % 4), 3'b000, 1);
        add(0, 0, 0, 0, 3'b000, 3'b000, 0);
        // Brake + left turn, then brake dropped mid-step.
        for (int k = 0; k < 6; k++) add(1, 0, 1, 0, 3'b111, pat(k / 4 + 1), 1);
        add(0, 0, 1, 0, 3'b000, 3'b011, 1);
        add(0, 0, 1, 0, 3'b000, 3'b011, 1);
        add(0, 0, 1, 0, 3'b000, 3'b111, 1);
        add(0, 0, 0, 0, 3'b000, 3'b000, 0);
        // Left to right direction change in one cycle restarts the pattern.
        for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 3'b000, pat(k / 4 + 1), 1);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 0, pat(k / 4 + 1), 3'b000, 1);
        add(0, 0, 0, 0, 3'b000, 3'b000, 0);
        // Hazard with brake held.
`ifdef HAZARD_EN
        for (int k = 0; k < 16; k++) begin
            add(1, 0, 0, 1, pat((k / 4 + 1) % 4), pat((k / 4 + 1) % 4), 1);
        end
        add(0, 0, 0, 0, 3'b000, 3'b000, 0);
`else
        add(1, 0, 0, 1, 3'b111, 3'b111, 0);
        add(1, 0, 0, 1, 3'b111, 3'b111, 0);
        add(0, 0, 0, 1, 3'b000, 3'b000, 0);
        add(0, 0, 0, 1, 3'b000, 3'b000, 0);
`endif

        // Reset state.
        #2;
        check("reset_state", 3'b000, 3'b000, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].b, vq[i].tr, vq[i].tl, vq[i].hz);
            check($sformatf("vec%0d", i), vq[i].er, vq[i].el, vq[i].ea);
        end

        // Asynchronous reset in the middle of a sequence.
        for (int k = 0; k < 5; k++) drive(0, 1, 0, 0);
        check("pre_reset_011", 3'b011, 3'b000, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 3'b000, 3'b000, 0);
        @(negedge clk);
        turn_right = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0);
            check($sformatf("post_reset%0d", k), 3'b000, 3'b000, 0);
        end

        // Restart after reset starts from one lamp with a full first step.
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 0);
            check($sformatf("relaunch%0d", k), 3'b000, pat(k / 4 + 1), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
